divider_arbiter: RTL and testbench

- Shares one dividerFsm instance among N_REQ requesters.
- Each requester has a valid/ready request channel. All requesters share one response channel, which carries the requester ID.
- The block uses round-robin arbitration. It registers the operands, sequences the divider's begin/done protocol, and holds results until the response is accepted.
- It sits between multiple datapath clients and the single iterative divider.

---
 rtl/divider_arbiter_pkg.sv | 23 ++
 rtl/dividerFsm.sv | 82 ++++++++
 rtl/divider_arbiter_rr.sv | 23 ++
 rtl/divider_arbiter.sv | 133 +++++++++++++
 tb/tb_divider_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/divider_arbiter_pkg.sv
// Shared types and the round-robin pick function for divider_arbiter.
package divider_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // First set bit of valid[n-1:0] searching ptr, ptr+1, ... with wrap; 0 if none.
  function automatic int unsigned rrPick(input logic [31:0] valid,
                                         input int unsigned n,
                                         input int unsigned ptr);
    int unsigned idx;
    rrPick = 0;
    for (int unsigned i = 0; i < n; i++) begin
      idx = (ptr + n - 1 - i) % n;
      if (valid[idx]) rrPick = idx;
    end
  endfunction

endpackage

// File: rtl/dividerFsm.sv
// Iterative restoring divider: i_begin loads, WIDTH shift/subtract steps, then a one-cycle o_done.
module dividerFsm #(
  parameter int WIDTH          = 8,
  parameter int ABSTRACT_MODEL = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_begin,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             r_run;
  logic             r_fin;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  assign w_shift = {r_r, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_d});
  // When w_ge holds the difference is below r_d, so it fits in WIDTH bits.
  assign w_sub   = w_shift[WIDTH-1:0] - r_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run  <= 1'b0;
      r_fin  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (i_cg) begin
      r_done <= r_fin;
      r_fin  <= 1'b0;
      if (i_begin && !r_run) begin
        r_run <= 1'b1;
        r_cnt <= '0;
      end else if (r_run) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_run <= 1'b0;
          r_fin <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_cg) begin
      if (i_begin && !r_run) begin
        r_q <= i_dividend;
        r_r <= '0;
        r_d <= i_divisor;
      end else if (r_run) begin
        if (ABSTRACT_MODEL != 0) begin
          if (r_cnt == LAST) begin
            r_q <= (i_divisor == '0) ? '1 : i_dividend / i_divisor;
            r_r <= (i_divisor == '0) ? i_dividend : i_dividend % i_divisor;
          end
        end else begin
          r_q <= {r_q[WIDTH-2:0], w_ge};
          r_r <= w_ge ? w_sub : w_shift[WIDTH-1:0];
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_q;
  assign o_remainder = r_r;

endmodule

// File: rtl/divider_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant and index of the first valid from pointer.
module rr_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  assign o_any = |i_valid;

  always_comb begin
    o_idx   = IW'(rrPick(32'(i_valid), N_REQ, 32'(i_ptr)));
    o_grant = '0;
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one dividerFsm among N_REQ valid/ready requesters with round-robin grant
// and a single held response channel tagged with the requester id.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int N_REQ          = 4,
  parameter int ABSTRACT_MODEL = 0,
  localparam int IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cg,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*WIDTH-1:0] i_req_dividend,
  input  logic [N_REQ*WIDTH-1:0] i_req_divisor,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [IW-1:0]          o_rsp_id,
  output logic [WIDTH-1:0]       o_rsp_quotient,
  output logic [WIDTH-1:0]       o_rsp_remainder,
  output logic                   o_rsp_dbz,
  output logic                   o_busy
);

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_id;
  logic             r_begin;
  logic             r_rsp_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_div_rst;
  logic             w_div_done;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH-1:0] w_div_r;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_div_rst = !i_rst_n;

  dividerFsm #(.WIDTH(WIDTH), .ABSTRACT_MODEL(ABSTRACT_MODEL)) u_div (
    .i_clk       (i_clk),
    .i_rst       (w_div_rst),
    .i_cg        (i_cg),
    .i_begin     (r_begin),
    .i_dividend  (r_dividend),
    .i_divisor   (r_divisor),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  assign o_req_ready = (r_state == IDLE && w_any) ? w_grant : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_begin     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (i_cg) begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id    <= w_idx;
            r_begin <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_begin <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_div_done) begin
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr       <= (r_id == IW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_cg) begin
      if (r_state == IDLE && w_any) begin
        r_dividend <= i_req_dividend[w_idx*WIDTH +: WIDTH];
        r_divisor  <= i_req_divisor[w_idx*WIDTH +: WIDTH];
      end
      if (r_state == WAIT && w_div_done) begin
        r_quot <= w_div_q;
        r_rem  <= w_div_r;
        r_dbz  <= (r_divisor == '0);
      end
    end
  end

  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_id        = r_id;
  assign o_rsp_quotient  = r_quot;
  assign o_rsp_remainder = r_rem;
  assign o_rsp_dbz       = r_dbz;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed self-checking bench for divider_arbiter (WIDTH=8, N_REQ=4).
module tb_divider_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cg;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dividend;
  logic [N*W-1:0] req_divisor;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_q;
  logic [W-1:0]   rsp_r;
  logic           rsp_dbz;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_arbiter #(.WIDTH(W), .N_REQ(N), .ABSTRACT_MODEL(0)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cg            (cg),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_dividend  (req_dividend),
    .i_req_divisor   (req_divisor),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_id        (rsp_id),
    .o_rsp_quotient  (rsp_q),
    .o_rsp_remainder (rsp_r),
    .o_rsp_dbz       (rsp_dbz),
    .o_busy          (busy)
  );

  typedef struct {
    int         req;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] d);
    req_dividend[k*W +: W] = a;
    req_divisor[k*W +: W]  = d;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cg        = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
  endtask

  // Called with the DUT idle and requests driven; returns one cycle after acceptance.
  task automatic transact(input int req, input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input int stall, input int cg_at,
                          input int exp_lat, input bit clr_valid);
    int k;
    chk("grant_ready", 32'(req_ready), 32'(1) << req);
    rsp_ready = (stall == 0);
    tick();
    if (clr_valid) req_valid[req] = 1'b0;
    chk("busy_after_hs", 32'(busy), 1);
    chk("ready_zero_busy", 32'(req_ready), 0);
    k = 0;
    while (!rsp_valid && k < 40) begin
      if (cg_at > 0 && k == cg_at) cg = 1'b0;
      if (cg_at > 0 && k == cg_at + 3) cg = 1'b1;
      tick();
      k++;
    end
    cg = 1'b1;
    chk("latency", 32'(k), 32'(exp_lat));
    chk("rsp_id", 32'(rsp_id), 32'(req));
    chk("quotient", 32'(rsp_q), 32'(eq));
    chk("remainder", 32'(rsp_r), 32'(er));
    chk("dbz", 32'(rsp_dbz), 32'(edbz));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_stable", {rsp_valid, 1'b0, rsp_id, rsp_dbz, rsp_q, rsp_r, req_ready},
          {1'b1, 1'b0, IW'(req), edbz, eq, er, 4'b0000});
    end
    rsp_ready = 1'b1;
    tick();
    chk("accept_valid_low", 32'(rsp_valid), 0);
    chk("accept_busy_low", 32'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{req: 2, a: 8'd200, d: 8'd7,   q: 8'd28,  r: 8'd4,  dbz: 1'b0};
    vecs[1] = '{req: 0, a: 8'd93,  d: 8'd0,   q: 8'd255, r: 8'd93, dbz: 1'b1};
    vecs[2] = '{req: 1, a: 8'd255, d: 8'd1,   q: 8'd255, r: 8'd0,  dbz: 1'b0};
    vecs[3] = '{req: 3, a: 8'd7,   d: 8'd9,   q: 8'd0,   r: 8'd7,  dbz: 1'b0};
    vecs[4] = '{req: 1, a: 8'd0,   d: 8'd5,   q: 8'd0,   r: 8'd0,  dbz: 1'b0};
    vecs[5] = '{req: 3, a: 8'd255, d: 8'd255, q: 8'd1,   r: 8'd0,  dbz: 1'b0};
    vecs[6] = '{req: 0, a: 8'd250, d: 8'd16,  q: 8'd15,  r: 8'd10, dbz: 1'b0};

    req_dividend = '0;
    req_divisor  = '0;
    do_reset();

    // A request withdrawn before any edge is never granted.
    req_valid = 4'b0010;
    #1;
    chk("pre_grant_ready", 32'(req_ready), 32'b0010);
    req_valid = '0;
    #1;
    chk("withdrawn_ready", 32'(req_ready), 0);
    tick();
    chk("withdrawn_idle", 32'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].req, vecs[i].a, vecs[i].d);
      req_valid = 4'b0001 << vecs[i].req;
      #1;
      transact(vecs[i].req, vecs[i].q, vecs[i].r, vecs[i].dbz, 0, 0, 11, 1'b1);
    end

    // Round robin from pointer 0 with all four requesting.
    do_reset();
    set_req(0, 8'd100, 8'd3);
    set_req(1, 8'd101, 8'd4);
    set_req(2, 8'd102, 8'd5);
    set_req(3, 8'd103, 8'd6);
    req_valid = 4'b1111;
    #1;
    transact(0, 8'd33, 8'd1, 1'b0, 0, 0, 11, 1'b0);
    transact(1, 8'd25, 8'd1, 1'b0, 0, 0, 11, 1'b0);
    transact(2, 8'd20, 8'd2, 1'b0, 0, 0, 11, 1'b0);
    transact(3, 8'd17, 8'd1, 1'b0, 0, 0, 11, 1'b0);
    transact(0, 8'd33, 8'd1, 1'b0, 0, 0, 11, 1'b0);
    req_valid = '0;

    // Backpressure: pointer is 1, requesters 0/1/2 valid -> 1 granted, held 20 cycles.
    set_req(1, 8'd60, 8'd7);
    req_valid = 4'b0111;
    #1;
    transact(1, 8'd8, 8'd4, 1'b0, 20, 0, 11, 1'b1);
    req_valid = '0;

    // Reset in the middle of WAIT drops the operation and returns pointer to 0.
    set_req(2, 8'd30, 8'd4);
    req_valid = 4'b0100;
    #1;
    chk("mid_grant_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    set_req(0, 8'd50, 8'd5);
    set_req(3, 8'd9, 8'd3);
    req_valid = 4'b1001;
    #1;
    transact(0, 8'd10, 8'd0, 1'b0, 0, 0, 11, 1'b1);
    req_valid = '0;

    // Clock gate low for three cycles during WAIT stretches latency by three.
    set_req(3, 8'd77, 8'd8);
    req_valid = 4'b1000;
    #1;
    transact(3, 8'd9, 8'd5, 1'b0, 0, 5, 14, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
